// File: rtl/sram_bist_supervisor_if.sv
// rtl/sram_bist_supervisor_if.sv - start/finish/mismatch handshake between supervisor and SRAM BIST engine
interface sram_bist_supervisor_if;
  logic BIST_start;
  logic BIST_finish;
  logic BIST_mismatch;

  modport master (
    output BIST_start,
    input  BIST_finish,
    input  BIST_mismatch
  );

  modport slave (
    input  BIST_start,
    output BIST_finish,
    output BIST_mismatch
  );
endinterface

// File: rtl/sram_bist_supervisor.sv
// rtl/sram_bist_supervisor.sv - launches repeated SRAM BIST runs, watches handshake/runtime, keeps pass/fail stats
module sram_bist_supervisor #(
  parameter int TIMEOUT_CYCLES = 600000,
  parameter int CNT_W          = 20,
  parameter int ACK_TIMEOUT    = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Run_request,
  input  logic [7:0]           Run_count,
  input  logic                 Abort,
  sram_bist_supervisor_if.master bist,
  output logic                 Busy,
  output logic                 Done,
  output logic [7:0]           Pass_count,
  output logic [7:0]           Fail_count,
  output logic [7:0]           First_fail_run,
  output logic                 Timeout_error,
  output logic [CNT_W-1:0]     Last_run_cycles
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_RUNNING,
    S_EVAL,
    S_END
  } state_t;

  state_t            state_q, state_d;
  logic              req_q;
  logic              start_q, start_d;
  logic              busy_d, done_d, timeout_d;
  logic [7:0]        pass_d, fail_d, first_d;
  logic [CNT_W-1:0]  last_d;
  logic              abort_q, abort_d;
  logic              fail_bit_q, fail_bit_d;
  logic [7:0]        run_idx_q, run_idx_d;
  logic [7:0]        target_q, target_d;
  logic [ACK_W-1:0]  ack_q, ack_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              req_edge;

  assign req_edge        = Run_request & ~req_q;
  assign bist.BIST_start = start_q;

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    busy_d     = Busy;
    done_d     = Done;
    timeout_d  = Timeout_error;
    pass_d     = Pass_count;
    fail_d     = Fail_count;
    first_d    = First_fail_run;
    last_d     = Last_run_cycles;
    abort_d    = abort_q;
    fail_bit_d = fail_bit_q;
    run_idx_d  = run_idx_q;
    target_d   = target_q;
    ack_d      = ack_q;
    cyc_d      = cyc_q;

    case (state_q)
      S_IDLE: begin
        if (req_edge) begin
          target_d  = Run_count;
          pass_d    = '0;
          fail_d    = '0;
          first_d   = '0;
          timeout_d = 1'b0;
          last_d    = '0;
          run_idx_d = 8'd1;
          abort_d   = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          start_d   = 1'b1;
          ack_d     = '0;
          state_d   = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        ack_d = ack_q + 1'b1;
        if (Abort) abort_d = 1'b1;
        if (!bist.BIST_finish) begin
          cyc_d   = '0;
          state_d = S_RUNNING;
        end else if (ack_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_END;
        end
      end

      S_RUNNING: begin
        cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
        if (Abort) abort_d = 1'b1;
        // A finish landing on the timeout cycle is still a valid run.
        if (bist.BIST_finish) begin
          last_d     = cyc_q;
          fail_bit_d = bist.BIST_mismatch;
          state_d    = S_EVAL;
        end else if (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          last_d    = cyc_q;
          state_d   = S_END;
        end
      end

      S_EVAL: begin
        if (fail_bit_q) begin
          fail_d = (Fail_count == 8'hFF) ? Fail_count : Fail_count + 8'd1;
          if (First_fail_run == 8'd0) first_d = run_idx_q;
        end else begin
          pass_d = (Pass_count == 8'hFF) ? Pass_count : Pass_count + 8'd1;
        end
        if (abort_q || Abort || (target_q != 8'd0 && run_idx_q == target_q)) begin
          state_d = S_END;
        end else begin
          run_idx_d = (run_idx_q == 8'hFF) ? run_idx_q : run_idx_q + 8'd1;
          start_d   = 1'b1;
          ack_d     = '0;
          state_d   = S_WAIT_ACK;
        end
      end

      S_END: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q         <= S_IDLE;
      req_q           <= 1'b0;
      start_q         <= 1'b0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      Timeout_error   <= 1'b0;
      Pass_count      <= '0;
      Fail_count      <= '0;
      First_fail_run  <= '0;
      Last_run_cycles <= '0;
      abort_q         <= 1'b0;
      fail_bit_q      <= 1'b0;
      run_idx_q       <= '0;
      target_q        <= '0;
      ack_q           <= '0;
      cyc_q           <= '0;
    end else begin
      state_q         <= state_d;
      req_q           <= Run_request;
      start_q         <= start_d;
      Busy            <= busy_d;
      Done            <= done_d;
      Timeout_error   <= timeout_d;
      Pass_count      <= pass_d;
      Fail_count      <= fail_d;
      First_fail_run  <= first_d;
      Last_run_cycles <= last_d;
      abort_q         <= abort_d;
      fail_bit_q      <= fail_bit_d;
      run_idx_q       <= run_idx_d;
      target_q        <= target_d;
      ack_q           <= ack_d;
      cyc_q           <= cyc_d;
    end
  end

endmodule
